// File: rtl/crc_transmitter.sv
`default_nettype none
// ============================================================================
// Module  : crc_transmitter
// Brief   : Bit-serial CRC encoder; emits {data, remainder} over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module crc_transmitter #(
    parameter int                BW      = 4,
    parameter int                CRC_BW  = 3,
    parameter logic [CRC_BW:0]   DIVISOR = 4'b1011
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [BW-1:0]        in_data,
    input  logic                 in_valid,
    input  logic                 in_err,
    output logic                 in_ready,
    output logic [BW+CRC_BW-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CNT_W = (BW > 1) ? $clog2(BW) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(BW - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [BW-1:0]           r_data;
    logic [BW-1:0]           r_shift;
    logic [CRC_BW-1:0]       r_crc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_shift;
    logic                    w_last;
    logic                    w_release;
    logic                    w_fb;
    logic [CRC_BW-1:0]       w_crc_next;
    logic [BW+CRC_BW-1:0]    w_codeword;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_next = S_HOLD;
            S_HOLD:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        w_accept  = (r_state == S_IDLE)  && in_valid;
        w_shift   = (r_state == S_SHIFT);
        w_release = (r_state == S_HOLD)  && out_ready;
    end

    // LFSR step: the message bit enters at the top of the remainder register
    assign w_last     = (r_cnt == c_last_bit);
    assign w_fb       = r_shift[BW-1] ^ r_crc[CRC_BW-1];
    assign w_crc_next = {r_crc[CRC_BW-2:0], 1'b0} ^ (w_fb ? DIVISOR[CRC_BW-1:0] : '0);
    assign w_codeword = {r_data, w_crc_next} ^ {{(BW+CRC_BW-1){1'b0}}, r_err};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_data    <= '0;
            r_shift   <= '0;
            r_crc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data  <= in_data;
                r_shift <= in_data;
                r_err   <= in_err;
                r_crc   <= '0;
                r_cnt   <= '0;
            end
            if (w_shift) begin
                r_crc   <= w_crc_next;
                r_shift <= {r_shift[BW-2:0], 1'b0};
                if (!w_last) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    out       <= w_codeword;
                    out_valid <= 1'b1;
                end
            end
            if (w_release) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_transmitter.sv
`default_nettype none
// ============================================================================
// Module  : tb_crc_transmitter
// Brief   : Self-checking bench; codewords compared to a long-division model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_crc_transmitter;

    localparam int              BW     = 4;
    localparam int              CRC_BW = 3;
    localparam int              CWW    = BW + CRC_BW;
    localparam logic [CRC_BW:0] DIV    = 4'b1011;

    logic             clk = 1'b0;
    logic             rstn;
    logic [BW-1:0]    in_data;
    logic             in_valid;
    logic             in_err;
    logic             in_ready;
    logic [CWW-1:0]   out;
    logic             out_valid;
    logic             out_ready;

    int n_checks = 0;
    int n_errors = 0;

    crc_transmitter #(.BW(BW), .CRC_BW(CRC_BW), .DIVISOR(DIV)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_err    (in_err),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Remainder of v modulo the generator, by textbook GF(2) long division
    function automatic logic [CRC_BW-1:0] poly_mod(input logic [CWW-1:0] v);
        logic [CWW-1:0] r;
        logic [CWW-1:0] d;
        r = v;
        d = CWW'(DIV);
        for (int i = CWW - 1; i >= CRC_BW; i--)
            if (r[i]) r = r ^ (d << (i - CRC_BW));
        return r[CRC_BW-1:0];
    endfunction

    function automatic logic [CWW-1:0] ref_codeword(input logic [BW-1:0] d, input logic e);
        logic [CWW-1:0] cw;
        cw = {d, poly_mod({d, {CRC_BW{1'b0}}})};
        cw[0] = cw[0] ^ e;
        return cw;
    endfunction

    // Paired receiver: returns the data on a zero remainder, otherwise 0
    function automatic logic [BW-1:0] rx_model(input logic [CWW-1:0] cw);
        return (poly_mod(cw) == '0) ? cw[CWW-1:CRC_BW] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_word(input logic [BW-1:0] d, input logic e);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        in_data  = d;
        in_err   = e;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_err   = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (out_valid) break;
        end
    endtask

    // One full transaction; stall = cycles out_ready is held low in HOLD
    task automatic run_word(input logic [BW-1:0] d, input logic e, input int stall, input string tag);
        int             lat;
        logic [CWW-1:0] exp_cw;
        exp_cw    = ref_codeword(d, e);
        out_ready = (stall == 0);
        accept_word(d, e);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'(BW));
        check({tag, "_out"}, 32'(out), 32'(exp_cw));
        for (int s = 0; s < stall; s++) begin
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_out"}, 32'(out), 32'(exp_cw));
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        check({tag, "_rx"}, 32'(rx_model(out)), e ? 32'd0 : 32'(d));
    endtask

    initial begin
        int lat;
        rstn      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'hF;
        in_err    = 1'b0;
        out_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out", 32'(out), 32'd0);
            check("rst_valid", 32'(out_valid), 32'd0);
        end
        rstn     = 1'b1;
        in_valid = 1'b0;
        tick();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_out_after", 32'(out), 32'd0);

        // Directed vectors with known codewords
        run_word(4'b1101, 1'b0, 0, "v1101");
        check("v1101_const", 32'(out), 32'b1101001);
        run_word(4'b1000, 1'b0, 0, "v1000");
        check("v1000_const", 32'(out), 32'b1000101);
        run_word(4'b0000, 1'b0, 0, "v0000");
        run_word(4'b1111, 1'b0, 0, "v1111");
        check("v1111_const", 32'(out), 32'b1111111);

        // Back-pressure with a competing word offered during HOLD
        out_ready = 1'b0;
        accept_word(4'b1101, 1'b0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'(BW));
        in_data  = 4'b0110;
        in_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            check("bp_out", 32'(out), 32'b1101001);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_drop", 32'(out_valid), 32'd0);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        for (int s = 0; s < BW + 2; s++) begin
            tick();
            check("bp_no_second", 32'(out_valid), 32'd0);
        end

        // Error injection flips the LSB and the receiver rejects it
        run_word(4'b1101, 1'b1, 0, "err");
        check("err_const", 32'(out), 32'b1101000);

        // Reset during the second SHIFT cycle aborts the word
        accept_word(4'b1101, 1'b0);
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        for (int s = 0; s < BW + 2; s++) begin
            tick();
            check("mid_rst_quiet", 32'(out_valid), 32'd0);
        end
        run_word(4'b1000, 1'b0, 0, "post_rst");

        // Loopback sweep of every word, back-to-back
        for (int d = 0; d < 16; d++) run_word(BW'(d), 1'b0, 0, "sweep");

        // Randomized words, error flags and stalls
        for (int i = 0; i < 40; i++) begin
            run_word(BW'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                     int'($urandom_range(0, 3)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
